// File: rtl/div_seq_ctrl.sv
// Iterative radix-2 restoring divider sequencer for DIV/DIVU/REM/REMU beside the execute stage.
// Optional build macro DIV_EARLY_OUT_EN skips the dividend's leading zeros before iterating.
module div_seq_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            rst_n,
  input  logic            clk,
  input  logic            div_req_i,
  input  logic [1:0]      div_ops_i,
  input  logic [XLEN-1:0] operand_1_i,
  input  logic [XLEN-1:0] operand_2_i,
  input  logic            kill_i,
  input  logic            ready_i,
  output logic            div_stall_o,
  output logic            div_busy_o,
  output logic            div_valid_o,
  output logic [XLEN-1:0] div_result_o
);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIXUP, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   op1_q, op1_d, op2_q, op2_d;
  logic [XLEN-1:0]   divisor_q, divisor_d;
  logic [XLEN-1:0]   rem_q, rem_d, quo_q, quo_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              q_neg_q, q_neg_d, r_neg_q, r_neg_d;

  logic              signed_op;
  logic [XLEN-1:0]   abs1, abs2, q_fix, r_fix;
  logic [XLEN:0]     rem_ext, trial;

`ifdef DIV_EARLY_OUT_EN
  logic [CNT_W-1:0]  lz;

  function automatic logic [CNT_W-1:0] count_lz(input logic [XLEN-1:0] v);
    logic [CNT_W-1:0] n;
    logic             seen;
    n    = '0;
    seen = 1'b0;
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (v[i]) seen = 1'b1;
      else if (!seen) n = n + 1'b1;
    end
    return n;
  endfunction
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;

    // DIV and REM (op bit 0 clear) are the signed flavours
    signed_op = ~op_q[0];
    abs1      = (signed_op && op1_q[XLEN-1]) ? -op1_q : op1_q;
    abs2      = (signed_op && op2_q[XLEN-1]) ? -op2_q : op2_q;
    rem_ext   = {rem_q, quo_q[XLEN-1]};
    trial     = rem_ext - {1'b0, divisor_q};
    q_fix     = (signed_op && q_neg_q) ? -quo_q : quo_q;
    r_fix     = (signed_op && r_neg_q) ? -rem_q : rem_q;
`ifdef DIV_EARLY_OUT_EN
    lz        = count_lz(abs1);
`endif

    case (state_q)
      IDLE: begin
        if (div_req_i && !kill_i) begin
          op_d    = div_ops_i;
          op1_d   = operand_1_i;
          op2_d   = operand_2_i;
          state_d = PREP;
        end
      end
      PREP: begin
        q_neg_d   = signed_op & (op1_q[XLEN-1] ^ op2_q[XLEN-1]);
        r_neg_d   = signed_op & op1_q[XLEN-1];
        divisor_d = abs2;
        rem_d     = '0;
`ifdef DIV_EARLY_OUT_EN
        quo_d     = abs1 << lz;
        cnt_d     = CNT_W'(XLEN) - lz;
`else
        quo_d     = abs1;
        cnt_d     = CNT_W'(XLEN);
`endif
        state_d   = ITER;
        if (op2_q == '0) begin
          result_d = op_q[1] ? op1_q : '1;
          state_d  = DONE;
        end else if (signed_op && op1_q == {1'b1, {(XLEN-1){1'b0}}} && op2_q == '1) begin
          result_d = op_q[1] ? '0 : op1_q;
          state_d  = DONE;
        end
`ifdef DIV_EARLY_OUT_EN
        else if (abs1 == '0) begin
          result_d = '0;
          state_d  = DONE;
        end
`endif
      end
      ITER: begin
        // A non-negative trial (no borrow into bit XLEN) means the divisor fits
        if (!trial[XLEN]) begin
          rem_d = trial[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = rem_ext[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = FIXUP;
      end
      FIXUP: begin
        result_d = op_q[1] ? r_fix : q_fix;
        state_d  = DONE;
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (kill_i && state_q != IDLE) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
    end
  end

  assign div_busy_o   = (state_q != IDLE);
  assign div_valid_o  = (state_q == DONE);
  assign div_result_o = result_q;
  assign div_stall_o  = (state_q == IDLE && div_req_i && !kill_i) ||
                        state_q == PREP || state_q == ITER || state_q == FIXUP ||
                        (state_q == DONE && !ready_i);

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed cases plus random ops against an arithmetic model.
// Honours DIV_EARLY_OUT_EN for the expected latency.
module tb_div_seq_ctrl;

  logic        rst_n, clk;
  logic        div_req_i, kill_i, ready_i;
  logic [1:0]  div_ops_i;
  logic [31:0] operand_1_i, operand_2_i;
  logic        div_stall_o, div_busy_o, div_valid_o;
  logic [31:0] div_result_o;

  int errors = 0;
  int checks = 0;

  div_seq_ctrl #(.XLEN(32), .CNT_W(6)) dut (
    .rst_n(rst_n), .clk(clk), .div_req_i(div_req_i), .div_ops_i(div_ops_i),
    .operand_1_i(operand_1_i), .operand_2_i(operand_2_i), .kill_i(kill_i),
    .ready_i(ready_i), .div_stall_o(div_stall_o), .div_busy_o(div_busy_o),
    .div_valid_o(div_valid_o), .div_result_o(div_result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed running, required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M-extension division semantics in plain arithmetic
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? a % b : a / b;
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    logic [31:0] mag;
    int          bits;
    if (b == 0) return 2;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    mag  = (!op[0] && a[31]) ? -a : a;
    bits = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) bits = i + 1;
`ifdef DIV_EARLY_OUT_EN
    if (mag == 0) return 2;
    return bits + 3;
`else
    return 35;
`endif
  endfunction

  // Issue one op with ready_i high; report the result seen while valid
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] res);
    int cyc;
    @(negedge clk);
    div_req_i = 1'b1; div_ops_i = op; operand_1_i = a; operand_2_i = b;
    #1 check("stall_on_req", 32'(div_stall_o), 32'd1);
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    div_req_i = 1'b0; operand_1_i = $urandom; operand_2_i = $urandom;
    while (!div_valid_o && cyc < 80) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    res = div_result_o;
    check("valid", 32'(div_valid_o), 32'd1);
    check("latency", 32'(cyc), 32'(ref_latency(op, a, b)));
    check("result", div_result_o, ref_result(op, a, b));
    @(posedge clk);
    @(negedge clk);
    check("idle_after", 32'({div_busy_o, div_valid_o}), 32'd0);
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] res;
    applyStimulus(op, a, b, res);
    check(tag, res, exp);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      4: return $urandom >> $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] res, exp, a, b;
    logic [1:0]  op;
    int          seen_valid;

    rst_n = 1'b0; div_req_i = 1'b0; kill_i = 1'b0; ready_i = 1'b1;
    div_ops_i = 2'd0; operand_1_i = '0; operand_2_i = '0;
    #12;
    check("reset_valid", 32'(div_valid_o), 32'd0);
    check("reset_busy", 32'(div_busy_o), 32'd0);
    check("reset_result", div_result_o, 32'd0);
    check("reset_stall", 32'(div_stall_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    checkOutput("divu_100_7", 2'd1, 32'd100, 32'd7, 32'd14);
    checkOutput("remu_100_7", 2'd3, 32'd100, 32'd7, 32'd2);
    checkOutput("div_m7_2", 2'd0, -32'sd7, 32'd2, 32'hFFFF_FFFD);
    checkOutput("rem_m7_2", 2'd2, -32'sd7, 32'd2, 32'hFFFF_FFFF);
    checkOutput("div_5_0", 2'd0, 32'd5, 32'd0, 32'hFFFF_FFFF);
    checkOutput("rem_5_0", 2'd2, 32'd5, 32'd0, 32'd5);
    checkOutput("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    checkOutput("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    checkOutput("divu_3_1", 2'd1, 32'd3, 32'd1, 32'd3);
    checkOutput("divu_0_9", 2'd1, 32'd0, 32'd9, 32'd0);

    // Kill at cycle 10 of a long DIVU: no valid, back to IDLE, then a clean op
    @(negedge clk);
    div_req_i = 1'b1; div_ops_i = 2'd1; operand_1_i = 32'hFFFF_FFFF; operand_2_i = 32'd3;
    @(posedge clk);
    @(negedge clk);
    div_req_i = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 9; i++) begin
      if (div_valid_o) seen_valid++;
      if (i == 8) kill_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    kill_i = 1'b0;
    check("kill_no_valid", 32'(seen_valid), 32'd0);
    check("kill_idle", 32'({div_busy_o, div_valid_o}), 32'd0);
    checkOutput("after_kill", 2'd1, 32'd1000, 32'd10, 32'd100);

    // req together with kill in IDLE is dropped
    @(negedge clk);
    div_req_i = 1'b1; kill_i = 1'b1; div_ops_i = 2'd1; operand_1_i = 32'd50; operand_2_i = 32'd5;
    #1 check("reqkill_stall", 32'(div_stall_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    div_req_i = 1'b0; kill_i = 1'b0;
    check("reqkill_idle", 32'(div_busy_o), 32'd0);

    // Backpressure with requests hammered while busy
    ready_i = 1'b0;
    exp = ref_result(2'd0, -32'sd100, 32'd7);
    @(negedge clk);
    div_req_i = 1'b1; div_ops_i = 2'd0; operand_1_i = -32'sd100; operand_2_i = 32'd7;
    @(posedge clk);
    for (int i = 0; i < 80 && !div_valid_o; i++) begin
      @(negedge clk);
      div_ops_i = 2'($urandom); operand_1_i = $urandom; operand_2_i = $urandom;
      if (!div_valid_o) @(posedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(div_valid_o), 32'd1);
      check("bp_result", div_result_o, exp);
      check("bp_stall", 32'(div_stall_o), 32'd1);
      @(posedge clk);
      @(negedge clk);
    end
    check("bp_result_const", div_result_o, 32'hFFFF_FFF2);
    ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release", 32'({div_busy_o, div_valid_o}), 32'd0);
    div_req_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("bp_req_not_taken", 32'(div_busy_o), 32'd0);

    for (int n = 0; n < 300; n++) begin
      op = 2'($urandom);
      a  = pick_operand();
      b  = pick_operand();
      if (b == 0 && $urandom_range(0, 3) != 0) b = 32'($urandom_range(1, 1000));
      applyStimulus(op, a, b, res);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
